multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control unit for the multi-cycle MIPS datapath. Decodes the 6-bit opcode into a Moore state sequence that drives every datapath strobe and mux select. Produces the 2-bit ALU operation class consumed by the ALU control decoder: 00 add, 01 subtract, 10 use funct, 11 and. Supports lw, sw, R-type, addi, andi, beq, bne and j.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction[31:26] from IR; valid from DECODE onward
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (beq)
- PCWriteCondNE  out  1  PC load if ALU not zero (bne)
- IorD  out  1  memory address: 0 = PC, 1 = ALUOut
- MemRead / MemWrite  out  1 each  memory strobes
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  write-back data: 0 = ALUOut, 1 = MDR
- RegDst  out  1  destination: 0 = rt, 1 = rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- ZeroExt  out  1  immediate extension: 1 = zero-extend, 0 = sign-extend
- ALUOp  out  2  operation class to the ALU control decoder
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- illegal  out  1  one-cycle pulse in DECODE on an unsupported opcode
- state  out  4  current state, for debug and verification

## Operation
- State register is 4 bits. Encoding:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC, 7 RWB
  - 8 BEQ, 9 JUMP, 10 BNE, 11 ADDIEX, 12 IWB, 13 ANDIEX
  - 14 and 15 are unused and return to FETCH on the next edge.
- Transitions:
  - FETCH→DECODE.
  - DECODE on opcode: 100011/101011→MEMADR; 000000→EXEC; 000100→BEQ; 000101→BNE; 000010→JUMP; 001000→ADDIEX; 001100→ANDIEX; any other opcode→FETCH with illegal=1.
  - MEMADR→MEMRD for lw, MEMWR for sw; opcode is re-sampled here.
  - MEMRD→MEMWB; EXEC→RWB; ADDIEX→IWB; ANDIEX→IWB.
  - MEMWB, MEMWR, RWB, IWB, BEQ, BNE, JUMP→FETCH.
- Outputs are a pure function of state (Moore). Any signal not listed for a state is 0.
  - FETCH: MemRead, IRWrite, PCWrite=1; ALUSrcB=01.
  - DECODE: ALUSrcB=11.
  - MEMADR: ALUSrcA=1, ALUSrcB=10.
  - MEMRD: MemRead=1, IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1.
  - MEMWR: MemWrite=1, IorD=1.
  - EXEC: ALUSrcA=1, ALUOp=10.
  - RWB: RegWrite=1, RegDst=1.
  - BEQ: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
  - BNE: as BEQ, but PCWriteCondNE=1 instead of PCWriteCond.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - ANDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11, ZeroExt=1.
  - IWB: RegWrite=1, RegDst=0, MemtoReg=0.
- PCWriteCond and PCWriteCondNE are never both 1.
- At most one of MemRead and MemWrite is 1 in any state.

## Timing
- Reset:
  - reset sampled high at a rising edge forces state=FETCH, regardless of the current state.
  - While reset=1, PCWrite, PCWriteCond, PCWriteCondNE, MemRead, MemWrite, IRWrite, RegWrite and illegal are forced to 0 combinationally. Mux selects show FETCH values.
  - First fetch occurs in the first cycle after reset deasserts.
  - A reset mid-instruction aborts it; no further strobe from that instruction is issued.
- Cycles per instruction, FETCH inclusive:
  - lw 5
  - sw, R-type, addi, andi 4
  - beq, bne, j 3
  - illegal 2
- opcode is sampled only in DECODE and MEMADR. Changes in other states have no effect.
- illegal is high for exactly the DECODE cycle in which the opcode is unsupported.

## Test plan
- Reset, then opcode=000000 held: state sequence 0,1,6,7,0. ALUOp=10 in state 6. RegWrite=1 and RegDst=1 only in state 7.
- lw (100011) then sw (101011) back-to-back:
  - lw visits states 0,1,2,3,4 with MemtoReg=1 in state 4.
  - sw visits 0,1,2,5 with MemWrite=1 and IorD=1 in state 5.
  - 9 cycles total.
- beq, then bne:
  - beq visits 0,1,8: ALUOp=01, PCWriteCond=1, PCSource=01, PCWriteCondNE=0.
  - bne visits 0,1,10: PCWriteCondNE=1, PCWriteCond=0.
- andi (001100) then addi (001000):
  - andi: state 13 with ALUOp=11 and ZeroExt=1.
  - addi: state 11 with ALUOp=00 and ZeroExt=0.
  - Both end in state 12 with RegWrite=1, RegDst=0.
- opcode=111111: state 0,1,0. illegal=1 only in the state-1 cycle. No RegWrite or MemWrite asserted.
- Reset asserted during state 3 of a lw: next state is 0, MemRead=0 while reset is high, and state 4 is never reached.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multi-cycle MIPS datapath (Moore, 4-bit state).
// Ports: clk/reset (sync, active-high), opcode[5:0] in; datapath strobes,
//   mux selects, ALUOp class, illegal pulse and debug state out.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       PCWriteCondNE,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ZeroExt,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9,
    S_BNE    = 4'd10,
    S_ADDIEX = 4'd11,
    S_IWB    = 4'd12,
    S_ANDIEX = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_e state_q, state_d;
  logic   illegal_d;
  state_e dec_state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; opcode is only looked at in DECODE and MEMADR.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BEQ;
          OP_BNE:       state_d = S_BNE;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_ANDI:      state_d = S_ANDIEX;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      // Anything other than sw falls through to the load path.
      S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_IWB;
      S_ANDIEX: state_d = S_IWB;
      default:  state_d = S_FETCH;  // terminal states and unused 14/15
    endcase
  end

  // While reset is held the mux selects look like FETCH so the datapath
  // is already steering PC+4 when the first real fetch happens.
  assign dec_state = reset ? S_FETCH : state_q;

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCWriteCondNE = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    MemtoReg      = 1'b0;
    RegDst        = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ZeroExt       = 1'b0;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;
    case (dec_state)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_DECODE: ALUSrcB = 2'b11;
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      S_RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_BNE: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        PCWriteCondNE = 1'b1;
        PCSource      = 2'b01;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b00;
      end
      S_ANDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
        ZeroExt = 1'b1;
      end
      S_IWB: RegWrite = 1'b1;
      default: ;
    endcase
    // Strobes are suppressed combinationally so a reset aborts immediately.
    if (reset) begin
      PCWrite       = 1'b0;
      PCWriteCond   = 1'b0;
      PCWriteCondNE = 1'b0;
      MemRead       = 1'b0;
      MemWrite      = 1'b0;
      IRWrite       = 1'b0;
      RegWrite      = 1'b0;
    end
  end

  assign illegal = illegal_d & ~reset;
  assign state   = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       PCWrite, PCWriteCond, PCWriteCondNE, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA, ZeroExt, illegal;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;

  multicycle_control dut (
    .clk(clk), .reset(reset), .opcode(opcode),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNE(PCWriteCondNE),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ZeroExt(ZeroExt), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, pcwc, pcwcne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb;
    logic       zext;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       ill;
  } ctl_t;

  ctl_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   path[$];

  // Control word the spec table prescribes for a state, with reset overrides.
  function automatic ctl_t exp_ctl(int st, bit rst, bit ill_op);
    ctl_t c;
    int   s;
    c = '0;
    s = rst ? 0 : st;
    case (s)
      0:  begin c.mrd = 1; c.irw = 1; c.pcw = 1; c.srcb = 2'b01; end
      1:  c.srcb = 2'b11;
      2:  begin c.srca = 1; c.srcb = 2'b10; end
      3:  begin c.mrd = 1; c.iord = 1; end
      4:  begin c.rw = 1; c.m2r = 1; end
      5:  begin c.mwr = 1; c.iord = 1; end
      6:  begin c.srca = 1; c.aluop = 2'b10; end
      7:  begin c.rw = 1; c.rdst = 1; end
      8:  begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
      9:  begin c.pcw = 1; c.pcsrc = 2'b10; end
      10: begin c.srca = 1; c.aluop = 2'b01; c.pcwcne = 1; c.pcsrc = 2'b01; end
      11: begin c.srca = 1; c.srcb = 2'b10; end
      12: c.rw = 1;
      13: begin c.srca = 1; c.srcb = 2'b10; c.aluop = 2'b11; c.zext = 1; end
      default: ;
    endcase
    if (rst) begin
      c.pcw = 0; c.pcwc = 0; c.pcwcne = 0; c.mrd = 0; c.mwr = 0; c.irw = 0; c.rw = 0;
    end
    c.st  = 4'(st);
    c.ill = (st == 1) && ill_op && !rst;
    return c;
  endfunction

  // Instruction class -> sequence of states visited, FETCH inclusive.
  task automatic build_path(input logic [5:0] op);
    case (op)
      6'b100011: path = '{0, 1, 2, 3, 4};
      6'b101011: path = '{0, 1, 2, 5};
      6'b000000: path = '{0, 1, 6, 7};
      6'b000100: path = '{0, 1, 8};
      6'b000101: path = '{0, 1, 10};
      6'b000010: path = '{0, 1, 9};
      6'b001000: path = '{0, 1, 11, 12};
      6'b001100: path = '{0, 1, 13, 12};
      default:   path = '{0, 1};
    endcase
  endtask

  task automatic cyc(input logic rst, input logic [5:0] op, input ctl_t e);
    @(posedge clk);
    #1;
    reset  = rst;
    opcode = op;
    exp_q.push_back(e);
  endtask

  // Drives one instruction; opcode is garbage outside DECODE/MEMADR.
  // abort_at >= 0 raises reset in that cycle of the instruction.
  task automatic run_instr(input logic [5:0] op, input int abort_at);
    bit         ill_op;
    logic [5:0] drv;
    bit         rst;
    build_path(op);
    ill_op = (path.size() == 2);
    for (int i = 0; i < path.size(); i++) begin
      rst = (i == abort_at);
      drv = (i == 1 || path[i] == 2) ? op : 6'($urandom_range(63));
      cyc(rst, drv, exp_ctl(path[i], rst, ill_op));
      if (rst) break;
    end
  endtask

  // Monitor: compares the DUT's control word each cycle there is an expectation.
  always @(negedge clk) begin
    ctl_t got, e;
    cycle++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got.st = state;       got.pcw = PCWrite;    got.pcwc = PCWriteCond;
      got.pcwcne = PCWriteCondNE; got.iord = IorD; got.mrd = MemRead;
      got.mwr = MemWrite;   got.irw = IRWrite;    got.m2r = MemtoReg;
      got.rdst = RegDst;    got.rw = RegWrite;    got.srca = ALUSrcA;
      got.srcb = ALUSrcB;   got.zext = ZeroExt;   got.aluop = ALUOp;
      got.pcsrc = PCSource; got.ill = illegal;
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL ctl_word cycle %0d reset=%0b: got %h (state %0d) expected %h (state %0d)",
                 cycle, reset, got, got.st, e, e.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  localparam logic [5:0] LEGAL [8] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                       6'b000101, 6'b000010, 6'b001000, 6'b001100};

  initial begin
    logic [5:0] op;
    int         ab;
    reset  = 1'b1;
    opcode = 6'b000000;
    @(posedge clk);
    // Held reset: state FETCH, strobes off, FETCH mux selects.
    cyc(1'b1, 6'b000000, exp_ctl(0, 1'b1, 1'b0));
    cyc(1'b1, 6'b000000, exp_ctl(0, 1'b1, 1'b0));

    // Directed program from the test plan.
    run_instr(6'b000000, -1);
    run_instr(6'b100011, -1);
    run_instr(6'b101011, -1);
    run_instr(6'b000100, -1);
    run_instr(6'b000101, -1);
    run_instr(6'b001100, -1);
    run_instr(6'b001000, -1);
    run_instr(6'b000010, -1);
    run_instr(6'b111111, -1);
    run_instr(6'b100011, 3);   // reset lands in MEMRD
    run_instr(6'b101011, -1);
    run_instr(6'b000101, 2);   // reset lands in BNE
    run_instr(6'b110000, 1);   // reset during an illegal DECODE masks the pulse

    // Random instruction stream with occasional aborts.
    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(4) == 0) op = 6'($urandom_range(63));
      else                        op = LEGAL[$urandom_range(7)];
      ab = ($urandom_range(11) == 0) ? int'($urandom_range(4)) : -1;
      run_instr(op, ab);
    end

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
